// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle between the pipeline datapath (master) and the fetch sequencer (slave).
// The counter width must match the CNT_W of the attached fetch_sequencer.
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic              imem_ack;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;

  logic              imem_req;
  logic              pc_write;
  logic              select_pc;
  logic [31:0]       branch;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    output imem_ack, branch_taken, branch_target, ex_mem_read,
           ex_rt, id_rs, id_rt, id_uses_rt,
    input  imem_req, pc_write, select_pc, branch, ifid_write,
           ifid_flush, idex_bubble, stall_cycles, redirect_count
  );

  modport slave (
    input  imem_ack, branch_taken, branch_target, ex_mem_read,
           ex_rt, id_rs, id_rt, id_uses_rt,
    output imem_req, pc_write, select_pc, branch, ifid_write,
           ifid_flush, idex_bubble, stall_cycles, redirect_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: decides PC advance/hold/redirect and IF/ID load/hold/flush,
// covering boot delay, imem wait states and load-use hazards, with saturating perf counters.
module fetch_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam int N_CNT = 2;  // index 0: stall cycles, index 1: redirects

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [3:0]                  r_boot_cnt;
  logic [3:0]                  w_boot_cnt_next;
  logic [31:0]                 r_target;
  logic [31:0]                 w_target_next;

  logic                        w_hz;
  logic [N_CNT-1:0]            w_cnt_inc;
  logic [N_CNT-1:0][CNT_W-1:0] w_cnt;

  logic                        w_imem_req;
  logic                        w_pc_write;
  logic                        w_select_pc;
  logic [31:0]                 w_branch;
  logic                        w_ifid_write;
  logic                        w_ifid_flush;
  logic                        w_idex_bubble;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign w_hz = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    w_state_next    = r_state;
    w_boot_cnt_next = r_boot_cnt;
    w_target_next   = r_target;
    w_cnt_inc       = '0;
    w_imem_req      = 1'b0;
    w_pc_write      = 1'b0;
    w_select_pc     = 1'b0;
    w_branch        = 32'd0;
    w_ifid_write    = 1'b0;
    w_ifid_flush    = 1'b1;
    w_idex_bubble   = 1'b1;

    if (!reset) begin
      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == 4'd0) begin
            w_state_next = ST_RUN;
          end else begin
            w_boot_cnt_next = r_boot_cnt - 4'd1;
          end
        end

        ST_RUN: begin
          w_imem_req    = 1'b1;
          w_branch      = bus.branch_target;
          w_ifid_flush  = 1'b0;
          w_idex_bubble = 1'b0;
          if (bus.branch_taken) begin
            w_select_pc   = 1'b1;
            w_ifid_write  = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = w_hz;
            w_cnt_inc[1]  = 1'b1;
            if (bus.imem_ack) begin
              w_pc_write = 1'b1;
            end else begin
              // Redirect is counted here once; the wait in PEND counts as stall only.
              w_target_next = bus.branch_target;
              w_state_next  = ST_PEND;
            end
          end else if (!bus.imem_ack) begin
            w_ifid_write  = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = w_hz;
            w_cnt_inc[0]  = 1'b1;
          end else if (w_hz) begin
            w_idex_bubble = 1'b1;
            w_cnt_inc[0]  = 1'b1;
          end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
          end
        end

        ST_PEND: begin
          w_imem_req    = 1'b1;
          w_select_pc   = 1'b1;
          w_branch      = r_target;
          w_ifid_write  = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b0;
          w_pc_write    = bus.imem_ack;
          if (bus.imem_ack) begin
            w_state_next = ST_RUN;
          end else begin
            w_cnt_inc[0] = 1'b1;
          end
        end

        default: begin
          w_state_next = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= 4'(BOOT_CYCLES - 1);
      r_target   <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_boot_cnt <= w_boot_cnt_next;
      r_target   <= w_target_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign bus.imem_req       = w_imem_req;
  assign bus.pc_write       = w_pc_write;
  assign bus.select_pc      = w_select_pc;
  assign bus.branch         = w_branch;
  assign bus.ifid_write     = w_ifid_write;
  assign bus.ifid_flush     = w_ifid_flush;
  assign bus.idex_bubble    = w_idex_bubble;
  assign bus.stall_cycles   = w_cnt[0];
  assign bus.redirect_count = w_cnt[1];

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: the PC register, the PC+4 / branch-target mux and the instruction memory.
- Each cycle it decides whether the PC advances, holds or redirects, and whether the IF/ID register loads, holds or is flushed.
- Resolves three sources of stall or redirect: the post-reset boot delay, instruction-memory wait states and EX-stage load-use hazards.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which fetch is held off. Legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_ack  input  1  instruction memory has valid data for the current PC this cycle.
- branch_taken  input  1  a branch/jump resolved taken this cycle.
- branch_target  input  32  target PC; valid when branch_taken=1.
- ex_mem_read  input  1  the instruction in EX is a load.
- ex_rt  input  5  destination register of the load in EX.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  the instruction in ID reads rt as a source.
- imem_req  output  1  fetch request to instruction memory.
- pc_write  output  1  PC register load enable.
- select_pc  output  1  PC mux select: 0 = PC+4, 1 = branch.
- branch  output  32  address presented to the PC mux branch input.
- ifid_write  output  1  IF/ID register load enable.
- ifid_flush  output  1  force IF/ID to a NOP this edge.
- idex_bubble  output  1  force ID/EX control signals to zero (bubble).
- stall_cycles  output  CNT_W  saturating count of held-fetch cycles.
- redirect_count  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- States: BOOT, RUN, PEND_BRANCH. Outputs are combinational from state and inputs; state, the target latch and the counters are registered.
- Reset (synchronous) sets:
  - state = BOOT, boot counter = BOOT_CYCLES-1, target latch = 0, both counters = 0.
  - While reset is high, outputs are: imem_req=0, pc_write=0, select_pc=0, branch=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Reset asserted in any state, including mid-PEND_BRANCH, discards the latched target. Reset wins over every other input.
- BOOT:
  - Outputs are the reset values.
  - Boot counter decrements each cycle; when it reaches 0, next state = RUN. BOOT therefore lasts exactly BOOT_CYCLES cycles.
- Load-use hazard, "hz": ex_mem_read and ex_rt != 0 and (ex_rt == id_rs, or (id_uses_rt and ex_rt == id_rt)). Register 0 never causes a hazard.
- RUN: imem_req=1, branch=branch_target. Priority is redirect > memory wait > hazard > normal.
  - branch_taken and imem_ack: select_pc=1, pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=hz. Stay in RUN; redirect_count increments.
  - branch_taken and !imem_ack: pc_write=0, ifid_flush=1, ifid_write=1. Latch branch_target; next state PEND_BRANCH; redirect_count increments. The redirect is counted once.
  - !branch_taken and !imem_ack: pc_write=0, ifid_write=1, ifid_flush=1 (a NOP enters ID), idex_bubble=hz. stall_cycles increments.
  - !branch_taken, imem_ack and hz: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. stall_cycles increments.
  - Otherwise: pc_write=1, select_pc=0, ifid_write=1, ifid_flush=0, idex_bubble=0.
- PEND_BRANCH:
  - imem_req=1, select_pc=1, branch=latched target, ifid_write=1, ifid_flush=1, idex_bubble=0. branch_taken is ignored.
  - pc_write=imem_ack. On imem_ack, next state = RUN; otherwise stall_cycles increments and the state is held.
- Counters: increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 with no wrap.
- Latency: a taken branch with imem_ack loads the target into the PC at the same edge; the fetch from the target is visible the following cycle.

Test Plan:
- Hold reset 3 cycles, then release with BOOT_CYCLES=2 and imem_ack=1 → pc_write=0 and ifid_flush=1 for exactly 2 cycles after release, then pc_write=1 and select_pc=0. Both counters remain 0.
- In RUN, set ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle, stall_cycles=1. Repeat with ex_rt=0 → no stall.
- branch_taken=1, branch_target=0x0000_0040, imem_ack=1 → select_pc=1, pc_write=1, ifid_flush=1, branch=0x40, redirect_count=1.
- branch_taken=1, target=0x80 with imem_ack=0 for 3 cycles, and branch_taken is changed to target 0x100 during the wait → branch stays 0x80 and pc_write=1 only on the ack cycle. Final counts: redirect_count=1, stall_cycles=2, then back to RUN.
- Assert reset while in PEND_BRANCH → next cycle outputs are the reset values. After boot, select_pc=0 (latched target discarded).
- With CNT_W=4, hold imem_ack=0 for 20 cycles → stall_cycles saturates at 15 and does not wrap.
